motor_mixer: RTL and testbench

Wishbone-mapped quad-X motor mixer that sits directly upstream of the PWM peripheral. Software writes throttle, roll, pitch and yaw commands. A small FSM then computes the four motor duties one per cycle, saturates each to the PWM resolution, and commits all four at once. The committed duties drive the PWM block's per-channel duty inputs.

---
 rtl/motor_mixer_pkg.sv | 31 +++
 rtl/motor_mixer_if.sv | 21 ++
 rtl/motor_mixer_mixer_sat.sv | 41 ++++
 rtl/motor_mixer.sv | 177 +++++++++++++++++
 tb/tb_motor_mixer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_mixer_pkg.sv
// Shared constants and types for the quad-X motor mixer.
package motor_mixer_pkg;

   // Register word indices
   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_THROTTLE = 4'd1;
   localparam logic [3:0] REG_ROLL     = 4'd2;
   localparam logic [3:0] REG_PITCH    = 4'd3;
   localparam logic [3:0] REG_YAW      = 4'd4;
   localparam logic [3:0] REG_DUTY0    = 4'd5;
   localparam logic [3:0] REG_DUTY1    = 4'd6;
   localparam logic [3:0] REG_DUTY2    = 4'd7;
   localparam logic [3:0] REG_DUTY3    = 4'd8;
   localparam logic [3:0] REG_STATUS   = 4'd9;

   // Mixer sequencing; CALC states are consecutive so the next one is state+1
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_CALC0  = 3'd2,
      ST_CALC1  = 3'd3,
      ST_CALC2  = 3'd4,
      ST_CALC3  = 3'd5,
      ST_COMMIT = 3'd6
   } mix_state_e;

   // Per-motor negate flags {R, P, Y}; entry k belongs to motor k
   //   m0 = T+R+P-Y, m1 = T-R+P+Y, m2 = T-R-P-Y, m3 = T+R-P+Y
   localparam logic [3:0][2:0] MIX_NEG = {3'b010, 3'b111, 3'b100, 3'b001};

endpackage

// File: rtl/motor_mixer_if.sv
// Wishbone slave bus bundle for the motor mixer register file.
interface motor_mixer_if;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;

   modport master (
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/motor_mixer_mixer_sat.sv
// Combinational signed mix of one motor channel, clamped to the duty range.
module mixer_sat #(
   parameter int unsigned bit_resolution = 8,
   parameter int unsigned cmd_width      = 10
) (
   input  logic [bit_resolution-1:0]  t,
   input  logic signed [cmd_width-1:0] r,
   input  logic signed [cmd_width-1:0] p,
   input  logic signed [cmd_width-1:0] y,
   input  logic [2:0]                  neg,
   output logic [bit_resolution-1:0]   duty,
   output logic                        clamp
);
   localparam int unsigned N  = bit_resolution;
   localparam int unsigned SW = N + 3;
   localparam logic signed [SW-1:0] DMAX = SW'((1 << N) - 1);

   logic signed [SW-1:0] t_x, r_x, p_x, y_x, sum;

   // Throttle is unsigned, commands are two's complement
   always_comb begin
      t_x = $signed(SW'(t));
      r_x = neg[2] ? -SW'(r) : SW'(r);
      p_x = neg[1] ? -SW'(p) : SW'(p);
      y_x = neg[0] ? -SW'(y) : SW'(y);
      sum = t_x + r_x + p_x + y_x;
   end

   // Saturate to [0, 2^N-1] and flag any clamp
   always_comb begin
      duty  = sum[N-1:0];
      clamp = 1'b0;
      if (sum[SW-1]) begin
         duty  = '0;
         clamp = 1'b1;
      end else if (sum > DMAX) begin
         duty  = '1;
         clamp = 1'b1;
      end
   end
endmodule

// File: rtl/motor_mixer.sv
// Wishbone-mapped quad-X mixer feeding the PWM duty inputs.
module motor_mixer
   import motor_mixer_pkg::*;
#(
   parameter int unsigned bit_resolution = 8,
   parameter int unsigned cmd_width      = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   motor_mixer_if.slave                wb,
   output logic [4*bit_resolution-1:0] duty_o,
   output logic                        duty_valid_o,
   output logic                        busy_o
);
   localparam int unsigned N = bit_resolution;
   localparam int unsigned W = cmd_width;

   logic                ack;
   logic [31:0]         dat_q;
   logic                enable, sat, overrun;
   logic [N-1:0]        throttle, sh_t;
   logic signed [W-1:0] roll, pitch, yaw, sh_r, sh_p, sh_y;
   logic [3:0][N-1:0]   stage;
   mix_state_e          state;

   logic        accept, wr, ctrl_wr, stat_wr, start_req, start_ok, abort;
   logic [3:0]  idx;
   logic [1:0]  calc_k;
   logic        calc_en;
   logic [N-1:0] mix_duty;
   logic        mix_clamp;
   logic [31:0] rd_data;
   logic        unused_bus;

   assign unused_bus = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

   // Bus decode; a write takes effect on the edge that raises ack
   assign accept    = wb.wb_stb_i & wb.wb_cyc_i & ~ack;
   assign wr        = accept & wb.wb_we_i;
   assign idx       = wb.wb_adr_i[5:2];
   assign ctrl_wr   = wr && (idx == REG_CTRL);
   assign stat_wr   = wr && (idx == REG_STATUS);
   assign start_req = ctrl_wr & wb.wb_dat_i[1] & wb.wb_dat_i[0];
   assign abort     = ctrl_wr & ~wb.wb_dat_i[0];
   assign start_ok  = start_req && (state == ST_IDLE);

   assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack;
   assign wb.wb_dat_o = dat_q;

   // Which motor the shared mixer is working on this cycle
   always_comb begin
      calc_k  = 2'd0;
      calc_en = 1'b1;
      case (state)
         ST_CALC0: calc_k = 2'd0;
         ST_CALC1: calc_k = 2'd1;
         ST_CALC2: calc_k = 2'd2;
         ST_CALC3: calc_k = 2'd3;
         default:  calc_en = 1'b0;
      endcase
   end

   mixer_sat #(.bit_resolution(N), .cmd_width(W)) u_mix (
      .t     (sh_t),
      .r     (sh_r),
      .p     (sh_p),
      .y     (sh_y),
      .neg   (MIX_NEG[calc_k]),
      .duty  (mix_duty),
      .clamp (mix_clamp)
   );

   // Register read mux
   always_comb begin
      rd_data = '0;
      case (idx)
         REG_CTRL:     rd_data = {29'd0, busy_o, 1'b0, enable};
         REG_THROTTLE: rd_data = 32'(throttle);
         REG_ROLL:     rd_data = 32'(roll);
         REG_PITCH:    rd_data = 32'(pitch);
         REG_YAW:      rd_data = 32'(yaw);
         REG_DUTY0:    rd_data = 32'(duty_o[0*N +: N]);
         REG_DUTY1:    rd_data = 32'(duty_o[1*N +: N]);
         REG_DUTY2:    rd_data = 32'(duty_o[2*N +: N]);
         REG_DUTY3:    rd_data = 32'(duty_o[3*N +: N]);
         REG_STATUS:   rd_data = {30'd0, overrun, sat};
         default:      rd_data = '0;
      endcase
   end

   // Two-cycle ack handshake and registered read data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack   <= 1'b0;
         dat_q <= '0;
      end else begin
         ack <= accept;
         if (accept && !wb.wb_we_i) dat_q <= rd_data;
      end
   end

   // Software-visible registers and sticky flags; a new set beats a clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enable   <= 1'b0;
         throttle <= '0;
         roll     <= '0;
         pitch    <= '0;
         yaw      <= '0;
         sat      <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (ctrl_wr) enable <= wb.wb_dat_i[0];
         if (wr && idx == REG_THROTTLE) throttle <= wb.wb_dat_i[N-1:0];
         if (wr && idx == REG_ROLL)     roll     <= wb.wb_dat_i[W-1:0];
         if (wr && idx == REG_PITCH)    pitch    <= wb.wb_dat_i[W-1:0];
         if (wr && idx == REG_YAW)      yaw      <= wb.wb_dat_i[W-1:0];
         sat     <= (sat & ~(stat_wr & wb.wb_dat_i[0]))
                  | (calc_en & mix_clamp & ~abort);
         overrun <= (overrun & ~(stat_wr & wb.wb_dat_i[1]))
                  | (start_req & (state != ST_IDLE));
      end
   end

   // Mixer sequencer: latch, four calc steps, commit; disable aborts at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         sh_t         <= '0;
         sh_r         <= '0;
         sh_p         <= '0;
         sh_y         <= '0;
         stage        <= '0;
         duty_o       <= '0;
         duty_valid_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         duty_valid_o <= 1'b0;
         if (abort) begin
            state  <= ST_IDLE;
            stage  <= '0;
            duty_o <= '0;
            busy_o <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_ok) begin
                     state  <= ST_LATCH;
                     busy_o <= 1'b1;
                  end
               end
               ST_LATCH: begin
                  sh_t  <= throttle;
                  sh_r  <= roll;
                  sh_p  <= pitch;
                  sh_y  <= yaw;
                  state <= ST_CALC0;
               end
               ST_CALC0, ST_CALC1, ST_CALC2, ST_CALC3: begin
                  stage[calc_k] <= mix_duty;
                  state         <= mix_state_e'(state + 3'd1);
               end
               ST_COMMIT: begin
                  duty_o       <= stage;
                  duty_valid_o <= 1'b1;
                  busy_o       <= 1'b0;
                  state        <= ST_IDLE;
               end
               default: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_motor_mixer.sv
// Scoreboard bench for motor_mixer with a high-level mixing/timing model.
module tb_motor_mixer;
   localparam int unsigned N = 8;
   localparam int unsigned W = 10;
   localparam int I_CTRL = 0, I_THR = 1, I_ROLL = 2, I_PITCH = 3, I_YAW = 4;
   localparam int I_DUTY0 = 5, I_DUTY1 = 6, I_STATUS = 9;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   motor_mixer_if bus ();
   logic [4*N-1:0] duty_o;
   logic           duty_valid_o;
   logic           busy_o;

   motor_mixer #(.bit_resolution(N), .cmd_width(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb           (bus),
      .duty_o       (duty_o),
      .duty_valid_o (duty_valid_o),
      .busy_o       (busy_o)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic [31:0] duty;
      int          cycle;
   } exp_t;
   exp_t sbq[$];

   // Reference model state
   int          m_t, m_r, m_p, m_y;
   bit          m_en, m_sat, m_ovr;
   logic [31:0] m_duty;
   int          run_end = -100;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Quad-X mixing straight from the motor equations, clamped to the duty range
   function automatic void model_mix(input int t, r, p, y, output logic [31:0] d, output bit clamped);
      int m[4];
      m[0] = t + r + p - y;
      m[1] = t - r + p + y;
      m[2] = t - r - p - y;
      m[3] = t + r - p + y;
      clamped = 1'b0;
      d = '0;
      for (int k = 0; k < 4; k++) begin
         if (m[k] < 0) begin m[k] = 0; clamped = 1'b1; end
         else if (m[k] > 255) begin m[k] = 255; clamped = 1'b1; end
         d[k*N +: N] = N'(m[k]);
      end
   endfunction

   function automatic logic [31:0] model_reg(input int idx);
      case (idx)
         I_CTRL:   return 32'(m_en);
         I_THR:    return 32'(m_t);
         I_ROLL:   return 32'(m_r);
         I_PITCH:  return 32'(m_p);
         I_YAW:    return 32'(m_y);
         5, 6, 7, 8: return 32'(m_duty[(idx-5)*N +: N]);
         I_STATUS: return {30'd0, m_ovr, m_sat};
         default:  return 32'd0;
      endcase
   endfunction

   // One Wishbone access; returns the accepting edge number and read data
   task automatic wb_xfer(input bit we, input int idx, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int acc);
      bit got;
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = 32'(idx) << 2;
      bus.wb_sel_i = 4'hf;
      bus.wb_dat_i = wdata;
      rdata = '0;
      acc = -1;
      @(negedge clk);
      check("ack_before_edge", 32'(bus.wb_ack_o), 32'd0);
      @(negedge clk);
      check("ack_latency", 32'(bus.wb_ack_o), 32'd1);
      got = bus.wb_ack_o;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         got = bus.wb_ack_o;
      end
      if (got) begin
         acc = cyc_cnt;
         rdata = bus.wb_dat_o;
      end else begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout: got no ack expected ack on idx %0d", idx);
      end
      @(posedge clk);
      #1;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [31:0] data);
      logic [31:0] rd_d;
      int acc;
      logic signed [W-1:0] cmd;
      logic [31:0] d;
      bit clamped;
      wb_xfer(1'b1, idx, data, rd_d, acc);
      cmd = data[W-1:0];
      case (idx)
         I_THR:   m_t = int'(data[N-1:0]);
         I_ROLL:  m_r = int'(cmd);
         I_PITCH: m_p = int'(cmd);
         I_YAW:   m_y = int'(cmd);
         I_STATUS: begin
            if (data[0]) m_sat = 1'b0;
            if (data[1]) m_ovr = 1'b0;
         end
         I_CTRL: begin
            if (!data[0]) begin
               m_en = 1'b0;
               m_duty = '0;
               if (acc <= run_end) begin
                  if (sbq.size() > 0) void'(sbq.pop_back());
                  run_end = -100;
               end
            end else begin
               m_en = 1'b1;
               if (data[1]) begin
                  if (acc <= run_end) m_ovr = 1'b1;
                  else begin
                     model_mix(m_t, m_r, m_p, m_y, d, clamped);
                     sbq.push_back('{duty: d, cycle: acc + 6});
                     run_end = acc + 6;
                     m_duty = d;
                     if (clamped) m_sat = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic rd(input int idx, input logic [31:0] exp, input string name);
      logic [31:0] rd_d;
      int acc;
      wb_xfer(1'b0, idx, 32'd0, rd_d, acc);
      check(name, rd_d, exp);
   endtask

   // Let any modelled run finish, then confirm the DUT is idle
   task automatic settle();
      while (cyc_cnt <= run_end) @(posedge clk);
      #1;
      check("busy_after_run", 32'(busy_o), 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every commit strobe must match the next expected commit
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (duty_valid_o) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: got strobe with duty 0x%08h expected none", duty_o);
            end else begin
               e = sbq.pop_front();
               check("commit_duty", duty_o, e.duty);
               check("commit_cycle", 32'(cyc_cnt), 32'(e.cycle));
               check("busy_at_commit", 32'(busy_o), 32'd0);
            end
         end
      end
   end

   initial begin
      int t, r, p, y, g, k;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_sel_i = '0;
      bus.wb_dat_i = '0;
      m_t = 0; m_r = 0; m_p = 0; m_y = 0;
      m_en = 0; m_sat = 0; m_ovr = 0; m_duty = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_duty", duty_o, 32'd0);
      check("rst_valid", 32'(duty_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("rst_dat", bus.wb_dat_o, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rd(I_CTRL, 32'd0, "rst_ctrl");
      rd(I_STATUS, 32'd0, "rst_status");

      // Nominal mix, no saturation
      wr(I_THR, 100); wr(I_ROLL, 10); wr(I_PITCH, 5); wr(I_YAW, 3);
      wr(I_CTRL, 1);
      wr(I_CTRL, 3);
      check("busy_in_run", 32'(busy_o), 32'd1);
      rd(I_CTRL, 32'h5, "ctrl_busy_bit");
      settle();
      rd(I_STATUS, 32'd0, "status_nominal");
      rd(I_DUTY1, 32'd98, "duty1_nominal");
      check("duty_nominal", duty_o, {8'd108, 8'd82, 8'd98, 8'd112});

      // Upper clamp, then clear sat
      wr(I_THR, 250); wr(I_ROLL, 20); wr(I_PITCH, 0); wr(I_YAW, 0);
      wr(I_CTRL, 3);
      settle();
      rd(I_STATUS, 32'h1, "status_sat_hi");
      wr(I_STATUS, 1);
      rd(I_STATUS, 32'h0, "status_cleared");

      // Lower clamp, negative roll readback
      wr(I_THR, 10); wr(I_ROLL, 32'hFFFF_FFE2);
      wr(I_CTRL, 3);
      settle();
      rd(I_STATUS, 32'h1, "status_sat_lo");
      rd(I_ROLL, 32'hFFFF_FFE2, "roll_sext");
      rd(I_DUTY0, 32'd0, "duty0_clamped");
      wr(I_STATUS, 1);

      // Unmapped index: write ignored, read zero
      wr(12, 32'hDEAD_BEEF);
      rd(12, 32'd0, "unmapped_read");

      // Start while busy, and a throttle change after the snapshot
      wr(I_THR, 100); wr(I_ROLL, 10); wr(I_PITCH, 5); wr(I_YAW, 3);
      wr(I_CTRL, 3);
      wr(I_CTRL, 3);
      wr(I_THR, 50);
      settle();
      rd(I_STATUS, model_reg(I_STATUS), "status_overrun");
      rd(I_DUTY0, 32'd112, "duty0_old_throttle");
      wr(I_STATUS, 3);

      // Start at E6 collides, start at E7 runs
      wr(I_CTRL, 3);
      idle_cycles(4);
      wr(I_CTRL, 3);
      settle();
      rd(I_STATUS, model_reg(I_STATUS), "status_e6");
      wr(I_STATUS, 3);
      wr(I_CTRL, 3);
      idle_cycles(5);
      wr(I_CTRL, 3);
      settle();
      rd(I_STATUS, model_reg(I_STATUS), "status_e7");

      // Disable mid-run aborts without a strobe
      wr(I_CTRL, 3);
      idle_cycles(1);
      wr(I_CTRL, 0);
      check("abort_duty", duty_o, 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      idle_cycles(8);
      rd(I_DUTY1, 32'd0, "abort_duty1");

      // Reset in the middle of a fresh run
      wr(I_CTRL, 1);
      wr(I_CTRL, 3);
      settle();
      wr(I_CTRL, 3);
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_duty", duty_o, 32'd0);
      check("midrst_valid", 32'(duty_valid_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("midrst_dat", bus.wb_dat_o, 32'd0);
      sbq.delete();
      run_end = -100;
      m_t = 0; m_r = 0; m_p = 0; m_y = 0;
      m_en = 0; m_sat = 0; m_ovr = 0; m_duty = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      idle_cycles(1);
      rd(I_CTRL, 32'd0, "post_rst_ctrl");
      rd(I_THR, 32'd0, "post_rst_thr");

      // Randomized runs with occasional second starts at random offsets
      wr(I_CTRL, 1);
      for (int it = 0; it < 40; it++) begin
         t = int'($urandom_range(0, 255));
         r = int'($urandom_range(0, 511)) - 256;
         p = int'($urandom_range(0, 511)) - 256;
         y = int'($urandom_range(0, 511)) - 256;
         wr(I_THR, 32'(t)); wr(I_ROLL, 32'(r)); wr(I_PITCH, 32'(p)); wr(I_YAW, 32'(y));
         wr(I_CTRL, 3);
         g = int'($urandom_range(0, 7));
         idle_cycles(g);
         if ($urandom_range(0, 1) == 1) wr(I_CTRL, 3);
         settle();
         rd(I_STATUS, model_reg(I_STATUS), "rand_status");
         k = int'($urandom_range(5, 8));
         rd(k, model_reg(k), "rand_duty");
         if ($urandom_range(0, 2) == 0) wr(I_STATUS, 3);
      end

      idle_cycles(4);
      check("scoreboard_drain", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
